// File: rtl/seq_pulse_ctrl.sv
// seq_pulse_ctrl: plays a table of DDS pulse slots (tune, settle, gate, delay).
// dds_frq_valid is a one-cycle load strobe with no back-pressure: the sine
// source must take dds_frq/dds_phase on the cycle the strobe is high, and
// signals readiness of its output through dds_out_valid (level, no handshake).
module seq_pulse_ctrl #(
  parameter int N_PULSE    = 4,
  parameter int SETTLE_CYC = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_we,
  input  logic [5:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  input  logic [4:0]  n_pulses,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [3:0]  cur_pulse,
  output logic [31:0] dds_frq,
  output logic [31:0] dds_phase,
  output logic        dds_frq_valid,
  input  logic        dds_out_valid,
  input  logic [15:0] dds_out,
  output logic        tx_en,
  output logic [15:0] tx_data,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, PULSE, DELAY, DONE} state_t;

  localparam logic [4:0] N_MAX     = 5'(N_PULSE);
  localparam logic [7:0] SETTLE_M1 = 8'(SETTLE_CYC - 1);

  logic [31:0] tab_frq [N_PULSE];
  logic [31:0] tab_ph  [N_PULSE];
  logic [31:0] tab_len [N_PULSE];
  logic [31:0] tab_dly [N_PULSE];

  state_t      state, nxt_state;
  logic        load_en, adv, n_ok, last_slot;
  logic [3:0]  load_idx;
  logic [4:0]  n_lat;
  logic [7:0]  settle_cnt;
  logic [31:0] len_cnt, dly_cnt;
  logic [31:0] sel_frq, sel_ph, sel_len, sel_dly;

  assign dbg_state = state;

  // Sequence table; writes to slots beyond the table simply match no entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_PULSE; k++) begin
        tab_frq[k] <= '0;
        tab_ph[k]  <= '0;
        tab_len[k] <= '0;
        tab_dly[k] <= '0;
      end
    end else if (cfg_we) begin
      for (int k = 0; k < N_PULSE; k++) begin
        if (cfg_addr[5:2] == 4'(k)) begin
          case (cfg_addr[1:0])
            2'd0:    tab_frq[k] <= cfg_wdata;
            2'd1:    tab_ph[k]  <= cfg_wdata;
            2'd2:    tab_len[k] <= cfg_wdata;
            default: tab_dly[k] <= cfg_wdata;
          endcase
        end
      end
    end
  end

  // Read port for the slot about to be loaded.
  always_comb begin
    sel_frq = '0;
    sel_ph  = '0;
    sel_len = '0;
    sel_dly = '0;
    for (int k = 0; k < N_PULSE; k++) begin
      if (load_idx == 4'(k)) begin
        sel_frq = tab_frq[k];
        sel_ph  = tab_ph[k];
        sel_len = tab_len[k];
        sel_dly = tab_dly[k];
      end
    end
  end

  // Next-state decode; zero-length pulse/delay phases are skipped outright,
  // and abort overrides everything including a pending load.
  always_comb begin
    nxt_state = state;
    load_en   = 1'b0;
    load_idx  = cur_pulse;
    adv       = 1'b0;
    n_ok      = (n_pulses != 5'd0) && (n_pulses <= N_MAX);
    last_slot = (({1'b0, cur_pulse} + 5'd1) >= n_lat);
    case (state)
      IDLE: begin
        if (start) begin
          if (n_ok) begin
            nxt_state = LOAD;
            load_en   = 1'b1;
            load_idx  = 4'd0;
          end else begin
            nxt_state = DONE;
          end
        end
      end
      LOAD: nxt_state = SETTLE;
      SETTLE: begin
        if ((settle_cnt >= SETTLE_M1) && dds_out_valid) begin
          if (len_cnt != 32'd0)      nxt_state = PULSE;
          else if (dly_cnt != 32'd0) nxt_state = DELAY;
          else                       adv = 1'b1;
        end
      end
      PULSE: begin
        if (len_cnt == 32'd1) begin
          if (dly_cnt != 32'd0) nxt_state = DELAY;
          else                  adv = 1'b1;
        end
      end
      DELAY: begin
        if (dly_cnt == 32'd1) adv = 1'b1;
      end
      DONE:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
    if (adv) begin
      if (last_slot) begin
        nxt_state = DONE;
      end else begin
        nxt_state = LOAD;
        load_en   = 1'b1;
        load_idx  = cur_pulse + 4'd1;
      end
    end
    if (abort) begin
      nxt_state = IDLE;
      load_en   = 1'b0;
    end
  end

  // State register and registered outputs, all derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      dds_frq_valid <= 1'b0;
      tx_en         <= 1'b0;
      tx_data       <= '0;
      dds_frq       <= '0;
      dds_phase     <= '0;
      cur_pulse     <= '0;
      n_lat         <= '0;
      len_cnt       <= '0;
      dly_cnt       <= '0;
      settle_cnt    <= '0;
    end else begin
      state         <= nxt_state;
      busy          <= (nxt_state == LOAD) || (nxt_state == SETTLE) ||
                       (nxt_state == PULSE) || (nxt_state == DELAY) ||
                       ((nxt_state == DONE) && (state != IDLE));
      done          <= (nxt_state == DONE);
      dds_frq_valid <= load_en;
      tx_en         <= (nxt_state == PULSE);
      tx_data       <= (nxt_state == PULSE) ? dds_out : 16'd0;
      if ((state == IDLE) && start && !abort) n_lat <= n_pulses;
      if (load_en) begin
        cur_pulse <= load_idx;
        dds_frq   <= sel_frq;
        dds_phase <= sel_ph;
        len_cnt   <= sel_len;
        dly_cnt   <= sel_dly;
      end else begin
        if (nxt_state == IDLE) cur_pulse <= '0;
        if (state == PULSE)    len_cnt   <= len_cnt - 32'd1;
        if (state == DELAY)    dly_cnt   <= dly_cnt - 32'd1;
      end
      if ((state == SETTLE) && (nxt_state == SETTLE)) begin
        if (settle_cnt != 8'hFF) settle_cnt <= settle_cnt + 8'd1;
      end else begin
        settle_cnt <= '0;
      end
    end
  end

endmodule

// File: doc/seq_pulse_ctrl.md
SEQ_PULSE_CTRL -- requirements
Module: seq_pulse_ctrl

Interface
REQ-001 Parameter N_PULSE, default 4: number of pulse slots in the sequence table, range 1..16.
REQ-002 Parameter SETTLE_CYC, default 8: clk cycles allowed for DDS settling after each retune, range 1..255.
REQ-003 Port clk  in  1  single system clock; all logic on its rising edge.
REQ-004 Port rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port cfg_we  in  1  table write strobe.
REQ-006 Port cfg_addr  in  6  table address = slot*4 + field (0 frq, 1 phase, 2 length, 3 delay).
REQ-007 Port cfg_wdata  in  32  table write data.
REQ-008 Port n_pulses  in  5  number of slots to play, sampled at start.
REQ-009 Port start  in  1  one-cycle request to run the sequence.
REQ-010 Port abort  in  1  stops the sequence immediately.
REQ-011 Port busy  out  1  high from the cycle after an accepted start until DONE is left.
REQ-012 Port done  out  1  one-cycle completion pulse.
REQ-013 Port cur_pulse  out  4  index of the slot being played.
REQ-014 Port dds_frq  out  32  tuning word to the sine source.
REQ-015 Port dds_phase  out  32  phase offset to the sine source.
REQ-016 Port dds_frq_valid  out  1  one-cycle load strobe to the sine source.
REQ-017 Port dds_out_valid  in  1  sine source output-valid.
REQ-018 Port dds_out  in  16  sine source sample, signed.
REQ-019 Port tx_en  out  1  transmit gate.
REQ-020 Port tx_data  out  16  gated sample; 0 whenever tx_en is 0.

Function
REQ-021 States: IDLE, LOAD, SETTLE, PULSE, DELAY, DONE.
REQ-022 IDLE: start=1, abort=0, n_pulses in 1..N_PULSE -> LOAD with slot 0; n_pulses=0 or >N_PULSE -> DONE directly with no DDS strobe.
REQ-023 start while not in IDLE is ignored.
REQ-024 LOAD (1 cycle): the slot's frq/phase are registered onto dds_frq/dds_phase, dds_frq_valid=1, and the slot's length/delay are latched into internal counters; next state is SETTLE.
REQ-025 SETTLE: counts SETTLE_CYC cycles, then exits only once dds_out_valid=1; it exits to PULSE if the latched length is non-zero, otherwise to DELAY.
REQ-026 PULSE: lasts exactly length cycles; tx_en=1, and tx_data = dds_out registered (1-cycle latency); then DELAY.
REQ-027 DELAY: lasts exactly delay cycles (0 means zero cycles); the delay of the last slot is also executed; then LOAD for the next slot, or DONE after slot n_pulses-1.
REQ-028 DONE (1 cycle): done=1 -> IDLE.
REQ-029 cur_pulse updates in LOAD and holds until the next LOAD; it returns to 0 in IDLE.
REQ-030 Table writes are accepted in any state and take effect at the next LOAD of that slot; writes to the active slot do not alter its latched length/delay but are visible on its next play.
REQ-031 Writes to a slot index >= N_PULSE are ignored.
REQ-032 Counters are 32-bit unsigned with no wrap; length = 0xFFFFFFFF runs the full count.
REQ-033 abort=1 in any state -> IDLE on the next edge: tx_en=0 and tx_data=0 in that same edge, done not asserted, table retained.
REQ-034 abort and start together in IDLE: abort wins, and the sequence does not start.
REQ-035 dds_frq/dds_phase hold their last value outside LOAD.

Reset
REQ-036 rst_n=0 asynchronously forces IDLE; busy, done, dds_frq_valid and tx_en are 0; dds_frq, dds_phase, tx_data, cur_pulse and all table entries are 0.
REQ-037 Reset mid-sequence is an abort with the table cleared; operation resumes on the first edge after rst_n rises.

Verification
REQ-038 Single pulse: slot0 = {frq 5000000, phase 0, length 20, delay 10}, n_pulses=1, dds_out_valid=1 -> dds_frq_valid one cycle after start; tx_en high for exactly 20 cycles beginning SETTLE_CYC+2 cycles after start; done 10 cycles after tx_en falls.
REQ-039 Two slots, phases 13421773 and 93952410 -> two dds_frq_valid strobes carrying those phases, cur_pulse 0 then 1.
REQ-040 Slot length=0, delay=5 -> no tx_en, DELAY of 5 cycles, sequence continues.
REQ-041 dds_out_valid held low for 30 cycles after LOAD -> PULSE entered only on the first cycle dds_out_valid=1.
REQ-042 abort during cycle 7 of PULSE -> tx_en=0 and busy=0 next cycle, no done; a subsequent start replays from slot 0.
REQ-043 n_pulses=0 with start -> done one cycle later, busy stays 0, dds_frq_valid stays 0.
